// File: rtl/seven_segment_scan.sv
// Multiplexed hex display scanner with double-buffered data, leading-zero blanking and PWM dimming.
// Buffer swaps happen only at frame boundaries, so a frame never shows a mix of old and new values.
module seven_segment_scan #(
  parameter int unsigned N_DIGITS   = 8,
  parameter int unsigned DIV_W      = 10,
  parameter int unsigned BRIGHT_W   = 3,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*N_DIGITS-1:0]   i_num,
  input  logic [N_DIGITS-1:0]     i_dp,
  input  logic                    i_load,
  input  logic                    i_blank_lz,
  input  logic [BRIGHT_W-1:0]     i_brightness,
  output logic [7:0]              o_abcdefg,
  output logic [N_DIGITS-1:0]     o_anodes,
  output logic                    o_frame_done
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]          SEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{ACTIVE_LOW}};

  logic [DIV_W-1:0]      r_p;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_active_num;
  logic [N_DIGITS-1:0]   r_active_dp;
  logic [4*N_DIGITS-1:0] r_pend_num;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic                  r_pend_valid;
  logic [7:0]            r_abcdefg;
  logic [N_DIGITS-1:0]   r_anodes;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_on;
  logic                  w_blank;
  logic                  w_nonzero_above;
  logic                  w_dp_bit;
  logic [3:0]            w_nib;
  logic [6:0]            w_glyph;
  logic [7:0]            w_seg;
  logic [N_DIGITS-1:0]   w_an;

  assign w_tick     = &r_p;
  assign w_boundary = w_tick && (r_idx == LAST_IDX);
  // PWM: the slot's top prescaler bits act as a ramp compared against the duty code.
  assign w_on       = (r_p[DIV_W-1 -: BRIGHT_W] <= i_brightness);

  always_comb begin
    w_nib           = 4'h0;
    w_dp_bit        = 1'b0;
    w_nonzero_above = 1'b0;
    w_an            = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == r_idx) begin
        w_nib    = r_active_num[4*k +: 4];
        w_dp_bit = r_active_dp[k];
        w_an[k]  = w_on;
      end
      if ((IDX_W'(k) >= r_idx) && (r_active_num[4*k +: 4] != 4'h0)) begin
        w_nonzero_above = 1'b1;
      end
    end
    w_blank = i_blank_lz && (r_idx != '0) && !w_nonzero_above;
  end

  always_comb begin
    w_glyph = 7'b0000000;
    case (w_nib)
      4'h0:    w_glyph = 7'b1111110;
      4'h1:    w_glyph = 7'b0110000;
      4'h2:    w_glyph = 7'b1101101;
      4'h3:    w_glyph = 7'b1111001;
      4'h4:    w_glyph = 7'b0110011;
      4'h5:    w_glyph = 7'b1011011;
      4'h6:    w_glyph = 7'b1011111;
      4'h7:    w_glyph = 7'b1110000;
      4'h8:    w_glyph = 7'b1111111;
      4'h9:    w_glyph = 7'b1111011;
      4'hA:    w_glyph = 7'b1110111;
      4'hB:    w_glyph = 7'b0011111;
      4'hC:    w_glyph = 7'b1001110;
      4'hD:    w_glyph = 7'b0111101;
      4'hE:    w_glyph = 7'b1001111;
      default: w_glyph = 7'b1000111;
    endcase
  end

  always_comb begin
    w_seg = 8'h00;
    if (w_on) begin
      w_seg = {(w_blank ? 7'b0000000 : w_glyph), w_dp_bit};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p          <= '0;
      r_idx        <= '0;
      r_active_num <= '0;
      r_active_dp  <= '0;
      r_pend_num   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_abcdefg    <= SEG_OFF;
      r_anodes     <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_p <= r_p + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_boundary && r_pend_valid) begin
        r_active_num <= r_pend_num;
        r_active_dp  <= r_pend_dp;
      end
      // A load on the boundary still lands in pending after the old contents moved out.
      if (i_load) begin
        r_pend_num   <= i_num;
        r_pend_dp    <= i_dp;
        r_pend_valid <= 1'b1;
      end else if (w_boundary) begin
        r_pend_valid <= 1'b0;
      end
      r_abcdefg    <= w_seg ^ SEG_OFF;
      r_anodes     <= w_an ^ AN_OFF;
      r_frame_done <= (r_p == '0) && (r_idx == '0);
    end
  end

  assign o_abcdefg    = r_abcdefg;
  assign o_anodes     = r_anodes;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Randomized bench for seven_segment_scan with a time-based reference model and directed scenarios.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_num;
  logic [7:0]  i_dp;
  logic        i_load;
  logic        i_blank_lz;
  logic [1:0]  i_brightness;
  logic [7:0]  o_abcdefg;
  logic [7:0]  o_anodes;
  logic        o_frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: time since reset plus the two buffers; slot and phase derived arithmetically.
  int          m_t = 0;
  logic [31:0] m_active = '0;
  logic [31:0] m_pend = '0;
  logic [7:0]  m_dp_active = '0;
  logic [7:0]  m_dp_pend = '0;
  bit          m_pv = 1'b0;

  logic [6:0] glyph_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seven_segment_scan #(
    .N_DIGITS  (8),
    .DIV_W     (4),
    .BRIGHT_W  (2),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_num       (i_num),
    .i_dp        (i_dp),
    .i_load      (i_load),
    .i_blank_lz  (i_blank_lz),
    .i_brightness(i_brightness),
    .o_abcdefg   (o_abcdefg),
    .o_anodes    (o_anodes),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int         ph;
    int         dg;
    bit         on;
    bit         blank;
    bit         bnd;
    logic [3:0] nib;
    logic [7:0] e_seg;
    logic [7:0] e_an;
    logic       e_fd;
    @(posedge clk);
    ph = m_t % 16;
    dg = (m_t / 16) % 8;
    if (i_reset) begin
      e_seg = 8'hFF;
      e_an  = 8'hFF;
      e_fd  = 1'b0;
      m_t = 0; m_active = '0; m_pend = '0; m_dp_active = '0; m_dp_pend = '0; m_pv = 1'b0;
    end else begin
      on    = (ph / 4) <= int'(i_brightness);
      nib   = 4'((m_active >> (4 * dg)) & 32'hF);
      blank = i_blank_lz && (dg > 0) && ((m_active >> (4 * dg)) == 32'h0);
      e_seg = on ? ~{(blank ? 7'b0 : glyph_tbl[nib]), m_dp_active[dg]} : 8'hFF;
      e_an  = on ? ~(8'h01 << dg) : 8'hFF;
      e_fd  = (ph == 0) && (dg == 0);
      bnd   = (ph == 15) && (dg == 7);
      if (bnd && m_pv) begin
        m_active    = m_pend;
        m_dp_active = m_dp_pend;
      end
      if (i_load) begin
        m_pend = i_num; m_dp_pend = i_dp; m_pv = 1'b1;
      end else if (bnd) begin
        m_pv = 1'b0;
      end
      m_t++;
    end
    #1;
    check("seg", 32'(o_abcdefg), 32'(e_seg));
    check("an", 32'(o_anodes), 32'(e_an));
    check("fd", 32'(o_frame_done), 32'(e_fd));
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      step();
      if (o_frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_wait", 32'(seen), 32'd1);
  endtask

  task automatic step_to(input int pos);
    for (int n = 0; n < 200 && (m_t % 128) != pos; n++) step();
    check("step_to", m_t % 128, pos);
  endtask

  task automatic load(input logic [31:0] num, input logic [7:0] dp);
    i_num = num; i_dp = dp; i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  initial begin
    int cnt [8];
    i_reset = 1'b1; i_num = '0; i_dp = '0; i_load = 1'b0;
    i_blank_lz = 1'b1; i_brightness = 2'd3;

    // Reset and first display
    step(); step();
    check("rst_an", 32'(o_anodes), 32'hFF);
    check("rst_seg", 32'(o_abcdefg), 32'hFF);
    check("rst_fd", 32'(o_frame_done), 32'd0);
    i_reset = 1'b0;
    step();
    check("post_rst_an0", 32'(o_anodes), 32'hFE);
    step();
    check("post_rst_an1", 32'(o_anodes), 32'hFE);

    // A5 with leading-zero blanking
    load(32'h000000A5, 8'h00);
    wait_frame();
    check("a5_d0", 32'(o_abcdefg), 32'b01001001);
    step_to(16);
    step();
    check("a5_d1", 32'(o_abcdefg), 32'b00010001);
    check("a5_d1_an", 32'(o_anodes), 32'hFD);
    step_to(48);
    step();
    check("a5_d3_blank", 32'(o_abcdefg), 32'hFF);
    check("a5_d3_an", 32'(o_anodes), 32'hF7);

    // Two loads in one frame: only the second one appears
    step_to(40);
    load(32'h0000000A, 8'h00);
    step_to(70);
    load(32'h00000005, 8'h00);
    check("dbl_before", 32'(o_abcdefg), 32'hFF);
    wait_frame();
    check("dbl_after", 32'(o_abcdefg), 32'b01001001);

    // Load exactly on the boundary tick with pending empty
    step_to(127);
    load(32'h0000000C, 8'h00);
    wait_frame();
    check("bnd_old", 32'(o_abcdefg), 32'b01001001);
    wait_frame();
    check("bnd_new", 32'(o_abcdefg), 32'b01100011);

    // PWM duty per digit
    for (int b = 0; b < 2; b++) begin
      i_brightness = (b == 0) ? 2'd0 : 2'd2;
      wait_frame();
      foreach (cnt[d]) cnt[d] = 0;
      for (int c = 0; c < 128; c++) begin
        for (int d = 0; d < 8; d++) if (o_anodes[d] == 1'b0) cnt[d]++;
        if (c != 127) step();
      end
      for (int d = 0; d < 8; d++) check((b == 0) ? "duty_b0" : "duty_b2", cnt[d], (b == 0) ? 4 : 12);
    end

    // Reset during slot 5 discards pending
    i_brightness = 2'd3;
    wait_frame();
    step_to(32);
    load(32'h0000FFFF, 8'hFF);
    step_to(85);
    i_reset = 1'b1;
    step();
    check("mid_rst_an", 32'(o_anodes), 32'hFF);
    check("mid_rst_seg", 32'(o_abcdefg), 32'hFF);
    i_reset = 1'b0;
    step();
    check("mid_rst_fd", 32'(o_frame_done), 32'd1);
    check("mid_rst_d0", 32'(o_abcdefg), 32'b00000011);
    wait_frame();
    check("mid_rst_no_pend", 32'(o_abcdefg), 32'b00000011);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_load = ($urandom_range(0, 19) == 0);
      i_num  = $urandom >> (4 * $urandom_range(0, 7));
      i_dp   = 8'($urandom);
      if ($urandom_range(0, 7) == 0) i_brightness = 2'($urandom);
      if ($urandom_range(0, 63) == 0) i_blank_lz = 1'($urandom);
      i_reset = ($urandom_range(0, 499) == 0);
      step();
    end
    i_reset = 1'b0; i_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
